vga_frame_reader: RTL and testbench
===================================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 clk  in  1  pixel clock (25 MHz nominal); the block's one clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 frame_data  in  12  frame-buffer read data, {R[3:0],G[3:0],B[3:0]}, valid exactly 1 clk after frame_rd.
REQ-008 pattern_en  in  1  1 = output colour bars instead of frame_data.
REQ-009 frame_addr  out  19  frame-buffer read address, raster order.
REQ-010 frame_rd  out  1  read strobe, high for each active pixel.
REQ-011 vga_r / vga_g / vga_b  out  4 each  pixel colour.
REQ-012 vga_hsync / vga_vsync  out  1 each  sync, active low.
REQ-013 frame_start  out  1  one-clk pulse aligned with first active pixel on the pins.

Function
REQ-014 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800) and wrap to 0; vcnt SHALL increment on hcnt wrap, 0..V_TOTAL-1 (525), and wrap to 0.
REQ-015 Active region SHALL be hcnt < H_ACTIVE and vcnt < V_ACTIVE; frame_rd = 1 exactly there (stage 0, registered).
REQ-016 Sync SHALL be low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], and for vcnt in [490,491].
REQ-017 frame_addr SHALL be an incrementing counter (no multiplier): +1 after each frame_rd cycle, held otherwise, reset to 0 when hcnt=0 and vcnt=0.
REQ-018 Last active address SHALL be H_ACTIVE*V_ACTIVE-1 = 307199; next frame restarts at 0, never 307200.
REQ-019 Pipeline: stage 0 counters/address/frame_rd; stage 1 data returns, sync/active delayed 1; stage 2 registered output pins. All outputs SHALL be 2 clk after the counter state that produced them, mutually aligned.
REQ-020 When delayed active = 0, vga_r/g/b SHALL be 0.
REQ-021 Colour bars: 8 bars of H_ACTIVE/8 pixels from hcnt: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
REQ-022 pattern_en SHALL be sampled only at hcnt=0, vcnt=0; mid-frame changes take effect next frame (no tearing).
REQ-023 frame_data SHALL be ignored in pattern mode; frame_rd still asserted (reader timing unchanged).
REQ-024 frame_start SHALL pulse once per frame, same cycle as pixel (0,0) on vga_r/g/b.

Reset
REQ-025 rst_n low SHALL asynchronously clear hcnt, vcnt, frame_addr, pipeline registers, sampled pattern mode; frame_rd=0, vga_r/g/b=0, frame_start=0, vga_hsync=1, vga_vsync=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release, timing restarts at (0,0), first frame_rd at the first clk edge with rst_n high, address 0.

Structure
REQ-027 Default timing constants (640x480@60 values above) and RGB444 field positions SHALL live in a shared package also used by the capture stage.
REQ-028 One sub-module is natural: vga_timing (hcnt/vcnt, active, sync generation); address, pattern and pixel pipeline stay in vga_frame_reader.

Verification
REQ-029 Release reset, run one frame -> hsync low 96 clk every 800; vsync low 2 lines (1600 clk) every 525 lines; 307200 frame_rd pulses per frame.
REQ-030 Memory model returning frame_data = addr[11:0] 1 clk after frame_rd -> pixel (x,y) on pins equals (y*640+x)[11:0]; first pixel 000, last 307199[11:0]=FFF.
REQ-031 Consecutive frames -> frame_addr 307199 followed by 0 at next frame; frame_start exactly once per frame, aligned with pixel (0,0).
REQ-032 pattern_en=1 at frame start -> x=0..79 FFF, 80..159 FF0, ..., 560..639 000; blanking 000.
REQ-033 Toggle pattern_en at line 240 -> current frame unchanged, next frame switches mode.
REQ-034 Assert rst_n low at line 100 pixel 300 for 3 clk -> outputs take reset values immediately; after release, frame_addr restarts at 0, sync timing restarts at (0,0).

Source files
------------

// File: rtl/vga_frame_reader_pkg.sv
// Shared VGA/RGB444 definitions: default 640x480@60 timing, pixel field
// positions and the colour-bar palette, used by the reader and the capture side.
package vga_frame_reader_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int ADDR_W = 19;
   localparam int RGB_W  = 12;
   localparam int R_MSB  = 11;
   localparam int R_LSB  = 8;
   localparam int G_MSB  = 7;
   localparam int G_LSB  = 4;
   localparam int B_MSB  = 3;
   localparam int B_LSB  = 0;

   typedef logic [RGB_W-1:0] rgb444_t;

   function automatic rgb444_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 12'hFFF;
         3'd1:    bar_colour = 12'hFF0;
         3'd2:    bar_colour = 12'h0FF;
         3'd3:    bar_colour = 12'h0F0;
         3'd4:    bar_colour = 12'hF0F;
         3'd5:    bar_colour = 12'hF00;
         3'd6:    bar_colour = 12'h00F;
         default: bar_colour = 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/vga_frame_reader_timing.sv
// Raster timing generator: registered h/v counters with active and sync flags,
// all describing the same (hcnt, vcnt) position.
module vga_frame_reader_timing #(
   parameter int  H_ACTIVE = 640,
   parameter int  H_FP     = 16,
   parameter int  H_SYNC   = 96,
   parameter int  H_BP     = 48,
   parameter int  V_ACTIVE = 480,
   parameter int  V_FP     = 10,
   parameter int  V_SYNC   = 2,
   parameter int  V_BP     = 33,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HCNT_W   = $clog2(H_TOTAL),
   localparam int VCNT_W   = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [HCNT_W-1:0] hcnt,
   output logic [VCNT_W-1:0] vcnt,
   output logic              active,
   output logic              hsync_n,
   output logic              vsync_n,
   output logic              sof_next
);

   localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
   localparam logic [HCNT_W-1:0] HS_BEG = HCNT_W'(H_ACTIVE + H_FP);
   localparam logic [HCNT_W-1:0] HS_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
   localparam logic [VCNT_W-1:0] VS_BEG = VCNT_W'(V_ACTIVE + V_FP);
   localparam logic [VCNT_W-1:0] VS_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic              run_q;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [VCNT_W-1:0] vcnt_q, vcnt_d;
   logic              active_q, active_d;
   logic              hsync_n_q, hsync_n_d;
   logic              vsync_n_q, vsync_n_d;

   // run_q is low only in the cycle after reset: the first edge lands on (0,0)
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (!run_q) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
         hcnt_d = hcnt_q + 1'b1;
      end
      active_d  = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
      hsync_n_d = !((hcnt_d >= HS_BEG) && (hcnt_d < HS_END));
      vsync_n_d = !((vcnt_d >= VS_BEG) && (vcnt_d < VS_END));
   end

   assign sof_next = (hcnt_d == '0) && (vcnt_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         active_q  <= 1'b0;
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
      end else begin
         run_q     <= 1'b1;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         active_q  <= active_d;
         hsync_n_q <= hsync_n_d;
         vsync_n_q <= vsync_n_d;
      end
   end

   assign hcnt    = hcnt_q;
   assign vcnt    = vcnt_q;
   assign active  = active_q;
   assign hsync_n = hsync_n_q;
   assign vsync_n = vsync_n_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out: raster address/read strobe, 1-clk read latency,
// optional colour bars, and registered VGA pins two clocks behind the counters.
module vga_frame_reader
   import vga_frame_reader_pkg::*;
#(
   parameter int  H_ACTIVE = H_ACTIVE_DEF,
   parameter int  H_FP     = H_FP_DEF,
   parameter int  H_SYNC   = H_SYNC_DEF,
   parameter int  H_BP     = H_BP_DEF,
   parameter int  V_ACTIVE = V_ACTIVE_DEF,
   parameter int  V_FP     = V_FP_DEF,
   parameter int  V_SYNC   = V_SYNC_DEF,
   parameter int  V_BP     = V_BP_DEF,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HCNT_W   = $clog2(H_TOTAL),
   localparam int VCNT_W   = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RGB_W-1:0]  frame_data,
   input  logic              pattern_en,
   output logic [ADDR_W-1:0] frame_addr,
   output logic              frame_rd,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic              frame_start
);

   localparam int                BAR_W     = H_ACTIVE / 8;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic              active, hsync_n, vsync_n, sof_next;
   logic [2:0]        bar_idx;

   logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
   logic              pat_mode_q, pat_mode_d;

   logic              vld_p1_q, vld_p1_d;
   logic              hsync_n_p1_q, hsync_n_p1_d;
   logic              vsync_n_p1_q, vsync_n_p1_d;
   logic              sof_p1_q, sof_p1_d;
   rgb444_t           bar_rgb_p1_q, bar_rgb_p1_d;

   rgb444_t           rgb_p2_q, rgb_p2_d;
   logic              hsync_n_p2_q, hsync_n_p2_d;
   logic              vsync_n_p2_q, vsync_n_p2_d;
   logic              sof_p2_q, sof_p2_d;

   vga_frame_reader_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk      (clk),
      .rst_n    (rst_n),
      .hcnt     (hcnt),
      .vcnt     (vcnt),
      .active   (active),
      .hsync_n  (hsync_n),
      .vsync_n  (vsync_n),
      .sof_next (sof_next)
   );

   always_comb begin
      // stage 0: address walks with the read strobe and never reaches H_ACTIVE*V_ACTIVE
      frame_addr_d = frame_addr_q;
      if (sof_next) begin
         frame_addr_d = '0;
      end else if (active) begin
         frame_addr_d = (frame_addr_q == ADDR_LAST) ? '0 : frame_addr_q + 1'b1;
      end
      pat_mode_d = sof_next ? pattern_en : pat_mode_q;

      bar_idx = '0;
      for (int i = 1; i < 8; i++) begin
         if (hcnt >= HCNT_W'(i * BAR_W)) bar_idx = 3'(i);
      end

      // stage 1: read data arrives; timing flags delayed to meet it
      vld_p1_d     = active;
      hsync_n_p1_d = hsync_n;
      vsync_n_p1_d = vsync_n;
      sof_p1_d     = active && (hcnt == '0) && (vcnt == '0);
      bar_rgb_p1_d = bar_colour(bar_idx);

      // stage 2: registered pins
      rgb_p2_d = '0;
      if (vld_p1_q) rgb_p2_d = pat_mode_q ? bar_rgb_p1_q : frame_data;
      hsync_n_p2_d = hsync_n_p1_q;
      vsync_n_p2_d = vsync_n_p1_q;
      sof_p2_d     = sof_p1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_addr_q <= '0;
         pat_mode_q   <= 1'b0;
         vld_p1_q     <= 1'b0;
         hsync_n_p1_q <= 1'b1;
         vsync_n_p1_q <= 1'b1;
         sof_p1_q     <= 1'b0;
         bar_rgb_p1_q <= '0;
         rgb_p2_q     <= '0;
         hsync_n_p2_q <= 1'b1;
         vsync_n_p2_q <= 1'b1;
         sof_p2_q     <= 1'b0;
      end else begin
         frame_addr_q <= frame_addr_d;
         pat_mode_q   <= pat_mode_d;
         vld_p1_q     <= vld_p1_d;
         hsync_n_p1_q <= hsync_n_p1_d;
         vsync_n_p1_q <= vsync_n_p1_d;
         sof_p1_q     <= sof_p1_d;
         bar_rgb_p1_q <= bar_rgb_p1_d;
         rgb_p2_q     <= rgb_p2_d;
         hsync_n_p2_q <= hsync_n_p2_d;
         vsync_n_p2_q <= vsync_n_p2_d;
         sof_p2_q     <= sof_p2_d;
      end
   end

   assign frame_addr  = frame_addr_q;
   assign frame_rd    = active;
   assign vga_r       = rgb_p2_q[R_MSB:R_LSB];
   assign vga_g       = rgb_p2_q[G_MSB:G_LSB];
   assign vga_b       = rgb_p2_q[B_MSB:B_LSB];
   assign vga_hsync   = hsync_n_p2_q;
   assign vga_vsync   = vsync_n_p2_q;
   assign frame_start = sof_p2_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a reduced 16x8 raster with a random-content
// frame buffer, a raster-position reference model and constant pattern vectors.
module tb_vga_frame_reader;

   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
   localparam int NPIX = HA * VA;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] frame_data = '0;
   logic        pattern_en = 1'b0;
   logic [18:0] frame_addr;
   logic        frame_rd;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync, frame_start;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_en = 1'b0;
   logic [11:0] mem [NPIX];
   bit mode [256];

   typedef struct {
      int          x;
      int          y;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        fs;
   } vec_t;
   vec_t tbl [15];

   always #5 clk = ~clk;

   vga_frame_reader #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_data  (frame_data),
      .pattern_en  (pattern_en),
      .frame_addr  (frame_addr),
      .frame_rd    (frame_rd),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .frame_start (frame_start)
   );

   // Frame buffer with one clock of read latency; junk when not read.
   always @(posedge clk)
      frame_data <= frame_rd ? mem[int'(frame_addr) % NPIX] : 12'($urandom);

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   // Pattern mode of each frame is the pattern_en level at the edge that starts it.
   always @(posedge clk)
      if (rst_n && (cyc % FT) == 0) mode[(cyc / FT) % 256] <= pattern_en;

   function automatic logic [11:0] bar_ref(input int x);
      case (x / (HA / 8))
         0: return 12'hFFF;
         1: return 12'hFF0;
         2: return 12'h0FF;
         3: return 12'h0F0;
         4: return 12'hF0F;
         5: return 12'hF00;
         6: return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rd"}, frame_rd, 0);
      check({tag, "_addr"}, frame_addr, 0);
      check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
      check({tag, "_hs"}, vga_hsync, 1);
      check({tag, "_vs"}, vga_vsync, 1);
      check({tag, "_fs"}, frame_start, 0);
   endtask

   task automatic wait_until(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("wait_cycle", cyc, target);
   endtask

   // Reference model: cycle k after reset release holds raster position k-1 at
   // the read side and k-3 on the pins.
   always @(negedge clk) begin
      int k, p, f, x, y, n;
      logic [11:0] e_rgb;
      logic act;
      if (model_en && rst_n) begin
         k = cyc;
         if (k >= 1) begin
            p = (k - 1) % FT;
            x = p % HT;
            y = p / HT;
            check("m_frame_rd", frame_rd, int'(x < HA && y < VA));
            n = (y < VA) ? y * HA + ((x < HA) ? x : HA) : NPIX;
            check("m_frame_addr", frame_addr, n % NPIX);
         end else begin
            check("m_frame_rd0", frame_rd, 0);
            check("m_frame_addr0", frame_addr, 0);
         end
         if (k >= 3) begin
            p = k - 3;
            f = p / FT;
            p = p % FT;
            x = p % HT;
            y = p / HT;
            act = (x < HA) && (y < VA);
            e_rgb = !act ? 12'h000 : (mode[f % 256] ? bar_ref(x) : mem[y * HA + x]);
            check("m_rgb", {vga_r, vga_g, vga_b}, e_rgb);
            check("m_hsync", vga_hsync, int'(!(x >= HA + HFP && x < HA + HFP + HS)));
            check("m_vsync", vga_vsync, int'(!(y >= VA + VFP && y < VA + VFP + VS)));
            check("m_frame_start", frame_start, int'(p == 0));
         end else begin
            check("m_rgb_pre", {vga_r, vga_g, vga_b}, 0);
            check("m_hsync_pre", vga_hsync, 1);
            check("m_vsync_pre", vga_vsync, 1);
            check("m_fs_pre", frame_start, 0);
         end
      end
   end

   initial begin
      int rd_cnt, hs_low, vs_low, fs_cnt;
      bit toggled;

      tbl[0]  = '{0,  0,  12'hFFF, 1'b1, 1'b1, 1'b1};
      tbl[1]  = '{16, 0,  12'h000, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{2,  1,  12'hFF0, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{18, 1,  12'h000, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{5,  2,  12'h0FF, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{20, 2,  12'h000, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{21, 2,  12'h000, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{6,  3,  12'h0F0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{9,  4,  12'hF0F, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{10, 5,  12'hF00, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{13, 6,  12'h00F, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{15, 7,  12'h000, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{3,  9,  12'h000, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{19, 10, 12'h000, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{0,  11, 12'h000, 1'b1, 1'b1, 1'b0};

      for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);

      rst_n = 1'b0;
      pattern_en = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("rst");

      model_en = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      check("first_rd", frame_rd, 1);
      check("first_addr", frame_addr, 0);

      // Frame 0 in pattern mode; pattern_en drops mid-frame and must not tear it.
      toggled = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (!toggled && tbl[i].y >= 4) begin
            pattern_en = 1'b0;
            toggled = 1'b1;
         end
         wait_until(tbl[i].y * HT + tbl[i].x + 3);
         check($sformatf("tbl%0d_rgb", i), {vga_r, vga_g, vga_b}, tbl[i].rgb);
         check($sformatf("tbl%0d_hs", i), vga_hsync, tbl[i].hs);
         check($sformatf("tbl%0d_vs", i), vga_vsync, tbl[i].vs);
         check($sformatf("tbl%0d_fs", i), frame_start, tbl[i].fs);
      end

      // Frame 1 shows memory data; last address then wraps to 0.
      wait_until(FT + (VA - 1) * HT + HA);
      check("addr_last", frame_addr, NPIX - 1);
      @(negedge clk);
      check("addr_wrap", frame_addr, 0);
      check("rd_after_last", frame_rd, 0);

      // Frame 2: one full period of strobes and syncs, random pattern_en changes.
      wait_until(2 * FT + 1);
      rd_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
      repeat (FT) begin
         rd_cnt += int'(frame_rd);
         hs_low += int'(!vga_hsync);
         vs_low += int'(!vga_vsync);
         fs_cnt += int'(frame_start);
         if ($urandom_range(0, 23) == 0) pattern_en = 1'($urandom);
         @(negedge clk);
      end
      check("rd_per_frame", rd_cnt, NPIX);
      check("hsync_low_per_frame", hs_low, HS * VT);
      check("vsync_low_per_frame", vs_low, VS * HT);
      check("fs_per_frame", fs_cnt, 1);

      // Frame 3: reset asserted mid-line, away from the clock edge.
      wait_until(3 * FT + 5 * HT + 7 + 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid_rst");
      repeat (3) @(negedge clk);
      check_reset_values("held_rst");
      pattern_en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_rd", frame_rd, 1);
      check("restart_addr", frame_addr, 0);
      wait_until(2 * FT + 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
